// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment constants, digit decode and converter state type
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}; non-decimal nibbles go dark
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// rtl/seg_scan_driver_bin2bcd.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state, state_nxt;
  logic [SR_W-1:0]  sr, sr_nxt, sr_adj;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  // DONE can chain straight into a new conversion so a queued value loses no cycle
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    case (state)
      CONV: begin
        sr_nxt  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W - 1))
          state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        if (start) begin
          sr_nxt    = {{BCD_W{1'b0}}, bin};
          cnt_nxt   = '0;
          state_nxt = CONV;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = sr[SR_W-1:BIN_W];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - N-digit multiplexed 7-segment driver with BCD conversion and blanking
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int N_DIGITS = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    bin,
  input  logic                load,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic [BIN_W-1:0]    leds,
  output logic                busy
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int PS_W  = $clog2(SCAN_DIV + 1);
  localparam int IDX_W = $clog2(N_DIGITS + 1);

  if (64'(10) ** N_DIGITS <= (64'(1) << BIN_W) - 64'(1)) begin : g_range_check
    $error("seg_scan_driver: N_DIGITS cannot hold the largest BIN_W value");
  end

  logic               conv_busy, conv_done, start;
  logic [BIN_W-1:0]   start_bin, conv_bin, pend_bin;
  logic               pend;
  logic [BCD_W-1:0]   conv_bcd, disp_bcd;
  logic [PS_W-1:0]    ps;
  logic [IDX_W-1:0]   idx;
  logic [N_DIGITS-1:0] blank;
  logic               hi_zero;
  logic [3:0]         cur_digit;

  bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (start_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // A load arriving in the DONE cycle parks in pending and is picked up from IDLE
  always_comb begin
    start     = 1'b0;
    start_bin = bin;
    if (!conv_busy) begin
      start     = load | pend;
      start_bin = load ? bin : pend_bin;
    end else if (conv_done) begin
      start     = pend;
      start_bin = pend_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_bin <= '0;
      conv_bin <= '0;
      disp_bcd <= '0;
      leds     <= '0;
    end else begin
      if (load && conv_busy) begin
        pend     <= 1'b1;
        pend_bin <= bin;
      end else if (start) begin
        pend <= 1'b0;
      end
      if (start)
        conv_bin <= start_bin;
      if (conv_done) begin
        disp_bcd <= conv_bcd;
        leds     <= conv_bin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps  <= '0;
      idx <= '0;
    end else if (ps == PS_W'(SCAN_DIV - 1)) begin
      ps  <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      ps <= ps + 1'b1;
    end
  end

  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      hi_zero  = hi_zero & (disp_bcd[4*i +: 4] == 4'd0);
      blank[i] = blank_lz & hi_zero;
    end
  end

  assign cur_digit = disp_bcd[4*int'(idx) +: 4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= blank[idx] ? SEG_OFF : seg_decode(cur_digit);
      an  <= ~(N_DIGITS'(1) << idx);
    end
  end

  assign busy = conv_busy;

endmodule
